// File: rtl/cache_nway_datapath_if.sv
// rtl/cache_nway_datapath_if.sv - controller-side bus of the N-way cache datapath
// Names carry the datapath's point of view: i_* flow into the datapath, o_* flow out.
interface cache_nway_datapath_if #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4
);
  localparam int s_mask = 2**s_offset;
  localparam int s_line = 8*s_mask;
  localparam int s_way  = $clog2(num_ways);

  logic [31:0]       i_addr;
  logic [s_way-1:0]  i_way_sel;
  logic              i_data_in_sel;
  logic [s_line-1:0] i_mem_wdata256;
  logic [s_mask-1:0] i_mem_byte_enable;
  logic [s_line-1:0] i_line_in;
  logic              i_load_data;
  logic              i_load_tag;
  logic              i_set_valid;
  logic              i_set_dirty;
  logic              i_clr_dirty;
  logic              i_update_lru;
  logic              i_flush_req;
  logic              o_hit;
  logic [s_way-1:0]  o_hit_way;
  logic [s_way-1:0]  o_victim_way;
  logic              o_victim_dirty;
  logic [s_line-1:0] o_data_out;
  logic [31:0]       o_addr_out;
  logic              o_flush_busy;
  logic              o_flush_done;

  modport master (
    output i_addr, i_way_sel, i_data_in_sel, i_mem_wdata256, i_mem_byte_enable, i_line_in,
           i_load_data, i_load_tag, i_set_valid, i_set_dirty, i_clr_dirty, i_update_lru,
           i_flush_req,
    input  o_hit, o_hit_way, o_victim_way, o_victim_dirty, o_data_out, o_addr_out,
           o_flush_busy, o_flush_done
  );

  modport slave (
    input  i_addr, i_way_sel, i_data_in_sel, i_mem_wdata256, i_mem_byte_enable, i_line_in,
           i_load_data, i_load_tag, i_set_valid, i_set_dirty, i_clr_dirty, i_update_lru,
           i_flush_req,
    output o_hit, o_hit_way, o_victim_way, o_victim_dirty, o_data_out, o_addr_out,
           o_flush_busy, o_flush_done
  );
endinterface

// File: rtl/cache_nway_datapath.sv
// rtl/cache_nway_datapath.sv - N-way set-associative cache datapath with tree PLRU
// Combinational hit/victim lookup, byte-enabled line writes and a self-timed invalidate sweep.
module cache_nway_datapath #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  cache_nway_datapath_if.slave  bus
);
  localparam int s_tag    = 32 - s_offset - s_index;
  localparam int s_mask   = 2**s_offset;
  localparam int s_line   = 8*s_mask;
  localparam int num_sets = 2**s_index;
  localparam int s_way    = $clog2(num_ways);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  logic [s_line-1:0]   r_data  [num_sets][num_ways];
  logic [s_tag-1:0]    r_tag   [num_sets][num_ways];
  logic [num_ways-1:0] r_valid [num_sets];
  logic [num_ways-1:0] r_dirty [num_sets];
  logic [num_ways-2:0] r_plru  [num_sets];
  state_t              r_state, w_state_nxt;
  logic [s_index-1:0]  r_cnt, w_cnt_nxt;

  logic [s_index-1:0]  w_index;
  logic [s_tag-1:0]    w_tag;
  logic                w_busy;
  logic                w_hit_any;
  logic [s_way-1:0]    w_hit_way;
  logic [s_way-1:0]    w_victim;
  logic [s_way-1:0]    w_lru_way;
  logic [s_line-1:0]   w_line_wr;

  // A way is the PLRU choice when every tree node on its path points toward it.
  function automatic logic [s_way-1:0] plru_victim(input logic [num_ways-2:0] t);
    logic [s_way-1:0] way;
    logic             on_path;
    int               node;
    way = '0;
    for (int v = 0; v < num_ways; v++) begin
      on_path = 1'b1;
      for (int l = 0; l < s_way; l++) begin
        node = (1 << l) - 1 + (v >> (s_way - l));
        if (t[node] != v[s_way-1-l]) on_path = 1'b0;
      end
      if (on_path) way = v[s_way-1:0];
    end
    return way;
  endfunction

  function automatic logic [num_ways-2:0] plru_touch(input logic [num_ways-2:0] t,
                                                     input logic [s_way-1:0]    w);
    for (int l = 0; l < s_way; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((int'(w) >> (s_way - l)) == p) t[(1 << l) - 1 + p] = ~w[s_way-1-l];
      end
    end
    return t;
  endfunction

  assign w_index   = bus.i_addr[s_index+s_offset-1:s_offset];
  assign w_tag     = bus.i_addr[31:s_index+s_offset];
  assign w_busy    = (r_state == S_SWEEP);
  assign w_lru_way = w_hit_any ? w_hit_way : bus.i_way_sel;

  // Scan downward so the lowest matching way is the one reported.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_hit_way = s_way'(w);
      end
    end
  end

  always_comb begin
    w_victim = plru_victim(r_plru[w_index]);
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!r_valid[w_index][w]) w_victim = s_way'(w);
    end
  end

  always_comb begin
    w_line_wr = r_data[w_index][bus.i_way_sel];
    for (int i = 0; i < s_mask; i++) begin
      if (bus.i_data_in_sel)               w_line_wr[8*i +: 8] = bus.i_line_in[8*i +: 8];
      else if (bus.i_mem_byte_enable[i])   w_line_wr[8*i +: 8] = bus.i_mem_wdata256[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_flush_req) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      S_SWEEP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == s_index'(num_sets - 1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int s = 0; s < num_sets; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_busy) begin
        r_valid[r_cnt] <= '0;
        r_dirty[r_cnt] <= '0;
        r_plru[r_cnt]  <= '0;
      end else begin
        if (bus.i_set_valid) r_valid[w_index][bus.i_way_sel] <= 1'b1;
        if (bus.i_set_dirty)      r_dirty[w_index][bus.i_way_sel] <= 1'b1;
        else if (bus.i_clr_dirty) r_dirty[w_index][bus.i_way_sel] <= 1'b0;
        if (bus.i_update_lru) r_plru[w_index] <= plru_touch(r_plru[w_index], w_lru_way);
      end
    end
  end

  // Line storage is never reset; validity alone decides whether contents matter.
  always_ff @(posedge i_clk) begin
    if (!w_busy) begin
      if (bus.i_load_data) r_data[w_index][bus.i_way_sel] <= w_line_wr;
      if (bus.i_load_tag)  r_tag[w_index][bus.i_way_sel]  <= w_tag;
    end
  end

  assign bus.o_hit          = w_hit_any & ~w_busy;
  assign bus.o_hit_way      = w_busy ? '0 : w_hit_way;
  assign bus.o_victim_way   = w_victim;
  assign bus.o_victim_dirty = r_dirty[w_index][w_victim];
  assign bus.o_data_out     = r_data[w_index][bus.i_way_sel];
  assign bus.o_addr_out     = {r_tag[w_index][bus.i_way_sel], w_index, {s_offset{1'b0}}};
  assign bus.o_flush_busy   = w_busy;
  assign bus.o_flush_done   = (r_state == S_DONE);
endmodule

// File: tb/tb_cache_nway_datapath.sv
// tb/tb_cache_nway_datapath.sv - self-checking bench for cache_nway_datapath
module tb_cache_nway_datapath;
  localparam int NW = 4;
  localparam int NS = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_nway_datapath_if bus ();
  cache_nway_datapath dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_valid [NS][NW];
  bit          m_dirty [NS][NW];
  bit          m_known [NS][NW];
  bit          m_tknown[NS][NW];
  bit          m_plru  [NS][NW-1];
  logic [23:0] m_tag   [NS][NW];
  logic [255:0] m_data [NS][NW];

  localparam logic [255:0] PAT_A = {4{64'hA1B2_C3D4_E5F6_0718}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_set(input logic [31:0] a);
    return int'(a[7:5]);
  endfunction

  function automatic int m_hitway(input logic [31:0] a);
    int s = m_set(a);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tknown[s][w] && m_tag[s][w] == a[31:8]) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int node = 0;
    int way  = 0;
    for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
    for (int l = 0; l < SW; l++) begin
      way  = way * 2 + int'(m_plru[s][node]);
      node = 2 * node + 1 + int'(m_plru[s][node]);
    end
    return way;
  endfunction

  task automatic m_touch(input int s, input int w);
    int node = 0;
    int dir;
    for (int l = 0; l < SW; l++) begin
      dir = (w >> (SW - 1 - l)) & 1;
      m_plru[s][node] = (dir == 0);
      node = 2 * node + 1 + dir;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 0;
    end
  endtask

  task automatic m_edge();
    int s  = m_set(bus.i_addr);
    int hw = m_hitway(bus.i_addr);
    int ws = int'(bus.i_way_sel);
    logic [255:0] nd;
    if (bus.i_load_data) begin
      nd = m_data[s][ws];
      if (bus.i_data_in_sel) nd = bus.i_line_in;
      else for (int i = 0; i < 32; i++)
        if (bus.i_mem_byte_enable[i]) nd[8*i +: 8] = bus.i_mem_wdata256[8*i +: 8];
      m_data[s][ws]  = nd;
      m_known[s][ws] = m_known[s][ws] | bus.i_data_in_sel;
    end
    if (bus.i_load_tag) begin
      m_tag[s][ws]    = bus.i_addr[31:8];
      m_tknown[s][ws] = 1;
    end
    if (bus.i_set_valid) m_valid[s][ws] = 1;
    if (bus.i_set_dirty)      m_dirty[s][ws] = 1;
    else if (bus.i_clr_dirty) m_dirty[s][ws] = 0;
    if (bus.i_update_lru) m_touch(s, (hw >= 0) ? hw : ws);
  endtask

  task automatic idle_in();
    bus.i_load_data = 0; bus.i_load_tag = 0; bus.i_set_valid = 0; bus.i_set_dirty = 0;
    bus.i_clr_dirty = 0; bus.i_update_lru = 0; bus.i_flush_req = 0;
    bus.i_data_in_sel = 0; bus.i_mem_byte_enable = '0;
  endtask

  task automatic tick(input bit apply);
    if (apply) m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string ph);
    int s  = m_set(bus.i_addr);
    int hw = m_hitway(bus.i_addr);
    int vw = m_victim(s);
    int ws = int'(bus.i_way_sel);
    chk({ph, "_hit"}, bus.o_hit, (hw >= 0));
    chk({ph, "_hit_way"}, bus.o_hit_way, (hw >= 0) ? hw : 0);
    chk({ph, "_victim_way"}, bus.o_victim_way, vw);
    chk({ph, "_victim_dirty"}, bus.o_victim_dirty, m_dirty[s][vw]);
    if (m_known[s][ws]) chk({ph, "_data_out"}, bus.o_data_out, m_data[s][ws]);
    if (m_tknown[s][ws])
      chk({ph, "_addr_out"}, bus.o_addr_out, {m_tag[s][ws], bus.i_addr[7:5], 5'b0});
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  task automatic fill(input logic [31:0] a, input int way, input logic [255:0] ln, input bit dirty);
    idle_in();
    bus.i_addr = a; bus.i_way_sel = SW'(way); bus.i_line_in = ln; bus.i_data_in_sel = 1;
    bus.i_load_data = 1; bus.i_load_tag = 1; bus.i_set_valid = 1; bus.i_set_dirty = dirty;
    tick(1);
    idle_in();
  endtask

  initial begin
    int hw;
    logic [255:0] exp_line;
    m_clear();
    idle_in();
    bus.i_addr = 32'h0000_1040; bus.i_way_sel = '0;
    bus.i_mem_wdata256 = '0; bus.i_line_in = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", bus.o_hit, 0);
    chk("rst_hit_way", bus.o_hit_way, 0);
    chk("rst_victim_way", bus.o_victim_way, 0);
    chk("rst_victim_dirty", bus.o_victim_dirty, 0);
    chk("rst_flush_busy", bus.o_flush_busy, 0);
    chk("rst_flush_done", bus.o_flush_done, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    fill(32'h0000_1040, 2, PAT_A, 0);
    bus.i_way_sel = 2'd2; #1;
    chk("fill_hit", bus.o_hit, 1);
    chk("fill_hit_way", bus.o_hit_way, 2);
    chk("fill_data", bus.o_data_out, PAT_A);
    chk("fill_addr_out", bus.o_addr_out, 32'h0000_1040);
    chk("fill_victim", bus.o_victim_way, 0);

    bus.i_mem_wdata256 = {256{1'b1}}; bus.i_mem_byte_enable = 32'h0000_000F;
    bus.i_data_in_sel = 0; bus.i_load_data = 1;
    tick(1);
    idle_in(); #1;
    exp_line = {PAT_A[255:32], 32'hFFFF_FFFF};
    chk("be_data", bus.o_data_out, exp_line);
    bus.i_mem_byte_enable = '0; bus.i_load_data = 1;
    tick(1);
    idle_in(); #1;
    chk("be_zero_nochange", bus.o_data_out, exp_line);
    bus.i_set_dirty = 1; bus.i_clr_dirty = 1;
    tick(1);
    idle_in(); #1;
    chk("dirty_other_victim", bus.o_victim_dirty, 0);

    fill(32'h0000_2040, 0, rnd_line(), 0);
    fill(32'h0000_3040, 1, rnd_line(), 0);
    fill(32'h0000_4040, 3, rnd_line(), 0);
    bus.i_addr = 32'h0000_9040;
    for (int w = 0; w < NW; w++) begin
      bus.i_way_sel = SW'(w); bus.i_update_lru = 1;
      tick(1);
    end
    idle_in(); #1;
    chk("plru_0123", bus.o_victim_way, 0);
    bus.i_way_sel = 2'd0; bus.i_update_lru = 1;
    tick(1);
    idle_in(); #1;
    chk("plru_then0", bus.o_victim_way, 2);
    chk("plru_victim_dirty", bus.o_victim_dirty, 1);
    check_all("dir");

    for (int c = 0; c < 300; c++) begin
      idle_in();
      bus.i_addr = {16'h0, 6'h0, 2'($urandom_range(0, 3)) | 8'h10, 3'($urandom), 5'($urandom)};
      bus.i_addr[15:8] = 8'h10 + 8'($urandom_range(0, 5));
      bus.i_way_sel = SW'($urandom);
      bus.i_data_in_sel = 1'($urandom);
      bus.i_mem_wdata256 = rnd_line();
      bus.i_line_in = rnd_line();
      bus.i_mem_byte_enable = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      bus.i_load_data = ($urandom_range(0, 2) == 0);
      bus.i_load_tag = ($urandom_range(0, 2) == 0);
      bus.i_set_valid = bus.i_load_tag & 1'($urandom);
      bus.i_set_dirty = ($urandom_range(0, 3) == 0);
      bus.i_clr_dirty = ($urandom_range(0, 3) == 0);
      bus.i_update_lru = 1'($urandom);
      hw = m_hitway(bus.i_addr);
      if (bus.i_load_tag && hw >= 0) bus.i_way_sel = SW'(hw);
      #1;
      check_all("rnd");
      tick(1);
    end

    fill(32'h0000_1000, m_victim(0), rnd_line(), 1);
    fill(32'h0000_10E0, m_victim(7), rnd_line(), 1);
    bus.i_addr = 32'h0000_1000; #1;
    chk("pre_flush_hit0", bus.o_hit, 1);
    bus.i_flush_req = 1;
    tick(1);
    for (int c = 1; c <= NS; c++) begin
      bus.i_load_data = 1'($urandom); bus.i_load_tag = 1'($urandom);
      bus.i_set_valid = 1; bus.i_set_dirty = 1; bus.i_update_lru = 1;
      bus.i_way_sel = SW'($urandom); bus.i_data_in_sel = 1; bus.i_line_in = rnd_line();
      bus.i_flush_req = 1'($urandom);
      #1;
      chk($sformatf("sweep_busy_c%0d", c), bus.o_flush_busy, 1);
      chk($sformatf("sweep_done_c%0d", c), bus.o_flush_done, 0);
      chk($sformatf("sweep_hit_c%0d", c), bus.o_hit, 0);
      tick(0);
    end
    idle_in();
    bus.i_flush_req = 1;
    m_clear();
    #1;
    chk("done_pulse", bus.o_flush_done, 1);
    chk("done_busy", bus.o_flush_busy, 0);
    tick(1);
    idle_in(); #1;
    chk("done_cleared", bus.o_flush_done, 0);
    chk("done_req_ignored", bus.o_flush_busy, 0);
    bus.i_addr = 32'h0000_1000; #1;
    check_all("post_flush_s0");
    chk("post_flush_vd0", bus.o_victim_dirty, 0);
    bus.i_addr = 32'h0000_10E0; #1;
    check_all("post_flush_s7");
    chk("post_flush_hit7", bus.o_hit, 0);

    fill(32'h0000_1060, 0, rnd_line(), 1);
    bus.i_flush_req = 1;
    tick(1);
    idle_in();
    tick(0);
    tick(0);
    chk("mid_busy_before", bus.o_flush_busy, 1);
    rst_n = 0;
    #1;
    m_clear();
    chk("mid_rst_busy", bus.o_flush_busy, 0);
    chk("mid_rst_done", bus.o_flush_done, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      chk("mid_no_done", bus.o_flush_done, 0);
      tick(1);
    end
    for (int s = 0; s < NS; s++) begin
      bus.i_addr = {16'h0, 8'h10, 3'(s), 5'h0};
      #1;
      check_all($sformatf("mid_set%0d", s));
      chk($sformatf("mid_victim_set%0d", s), bus.o_victim_way, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_nway_datapath.md
Name: cache_nway_datapath

Overview:
Parametrised N-way set-associative cache datapath; successor to the fixed 2-way datapath. Holds per-way data/tag/valid/dirty arrays plus a per-set tree pseudo-LRU. Performs same-cycle hit detection and victim selection, and byte-enabled line writes. Adds a self-timed flush sweep that invalidates every set. Sits between the cache controller FSM and the line adapter/physical memory.

Parameters:
s_offset, 5, byte-offset bits; line = 2**s_offset bytes
s_index, 3, set-index bits
s_tag, 32-s_offset-s_index, tag width
s_mask, 2**s_offset, byte-enable width
s_line, 8*s_mask, line width in bits
num_sets, 2**s_index, number of sets
num_ways, 4, associativity; power of 2, >=2
s_way, $clog2(num_ways), way-index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
addr  in  32  CPU address; index=addr[s_index+s_offset-1:s_offset], tag=addr[31:s_index+s_offset]
way_sel  in  s_way  way targeted by load_*/dirty ops, data_out and addr_out
data_in_sel  in  1  0: mem_wdata256 under byte enables; 1: line_in, full line
mem_wdata256  in  s_line  CPU write data
mem_byte_enable  in  s_mask  per-byte write enable for data_in_sel=0
line_in  in  s_line  fill line from memory
load_data  in  1  write data array of way_sel at index
load_tag  in  1  write tag of way_sel at index
set_valid  in  1  set valid of way_sel at index
set_dirty  in  1  set dirty of way_sel at index
clr_dirty  in  1  clear dirty of way_sel at index
update_lru  in  1  mark hit_way (if hit) else way_sel as most-recently-used
flush_req  in  1  start invalidate sweep
hit  out  1  any valid way's tag matches
hit_way  out  s_way  lowest matching way; 0 when no hit
victim_way  out  s_way  replacement way for current index
victim_dirty  out  1  dirty bit of victim_way
data_out  out  s_line  data of way_sel at index
addr_out  out  32  {tag of way_sel, index, s_offset zeros}; writeback address
flush_busy  out  1  sweep in progress
flush_done  out  1  one-cycle pulse after sweep completes

Behaviour:
- Reads are combinational from current index; all writes on rising clk.
- Reset (rst=0, async): all valid, dirty, PLRU bits 0; FSM IDLE; sweep counter 0; flush_busy=0, flush_done=0. Tag/data arrays not reset. After reset: hit=0, hit_way=0, victim_way=0, victim_dirty=0.
- hit = OR over ways of (valid & tag match). Multiple matches are illegal; hit_way reports the lowest.
- Data write: data_in_sel=0 writes only bytes with mem_byte_enable[i]=1 (all-zero enable => no change). data_in_sel=1 writes the full line.
- set_dirty and clr_dirty both high: set_dirty wins.
- Victim: lowest-indexed invalid way if any; else PLRU way. PLRU is a heap-ordered tree of num_ways-1 bits. Bit 0 = go left. On update, every node on the accessed way's path points away from it (1 if way is in the left subtree, else 0).
- FSM IDLE/SWEEP/DONE:
  - IDLE + flush_req -> SWEEP, counter=0.
  - SWEEP: each cycle clear valid, dirty and PLRU of set[counter], then counter++. At counter=num_sets-1 -> DONE.
  - DONE: flush_done=1 for one cycle -> IDLE.
  - Latency: flush_req edge to flush_done = num_sets+1 cycles.
- While flush_busy=1: load_data/load_tag/set_valid/set_dirty/clr_dirty/update_lru ignored; hit forced 0; flush_req ignored.
- flush_req in DONE is ignored.
- Reset mid-sweep: immediate IDLE, all state cleared as above.
- Sweep does not write back dirty lines; controller must clean first.

Test Plan:
- Reset, addr=0x0000_1040 -> hit=0, victim_way=0, victim_dirty=0, flush_busy=0.
- Fill way 2 at addr 0x0000_1040: line_in=pattern A, data_in_sel=1, way_sel=2, load_data+load_tag+set_valid, one cycle -> next cycle hit=1, hit_way=2, data_out(way_sel=2)=A, addr_out=0x0000_1040.
- Byte-enable write to that line: mem_wdata256=all 0xFF, mem_byte_enable=0x0000_000F, way_sel=2 -> bytes 0-3 =0xFF, bytes 4-31 = A unchanged; after set_dirty, victim_dirty follows victim_way only.
- 4-way, one set filled in all ways; update_lru on ways 0,1,2,3 in order -> victim_way=0. Then update_lru on way 0 -> victim_way=2.
- Fill valid+dirty lines in sets 0 and 7, pulse flush_req -> flush_busy high 8 cycles, flush_done one cycle at cycle 9, then hit=0 and victim_dirty=0 for both sets. Load strobes during sweep have no effect.
- Assert rst=0 at sweep cycle 3 -> flush_busy=0 immediately, no flush_done; all sets invalid after release.
